// File: rtl/pingpong_ctrl_pkg.sv
// Shared constants for the ping-pong frame buffer controller.
//   PP_AW / PP_DW / PP_DEPTH / PP_RD_LAT : default address width, word width,
//                                          words per bank, RAM read latency
//   ST_INIT / ST_RUN                     : controller state encoding
package pingpong_ctrl_pkg;

    localparam int PP_AW     = 11;
    localparam int PP_DW     = 12;
    localparam int PP_DEPTH  = 2048;
    localparam int PP_RD_LAT = 2;

    // state   | meaning
    // INIT    | no bank has been completed and handed to the reader yet
    // RUN     | at least one swap granted; reader data is live
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pingpong_ctrl_pp_delay.sv
// pp_delay: LAT-stage shift register that re-times the reader bank select
// so it lines up with data returning from the RAMs.
//   clk     : clock
//   rst     : asynchronous active-low reset (clears every stage)
//   in_bit  : bank select at the time the read was issued
//   out_bit : the same value LAT cycles later
module pp_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic out_bit
);

    generate
        if (LAT == 0) begin : g_bypass
            assign out_bit = in_bit;
        end else begin : g_pipe
            logic [LAT-1:0] pipe_q;
            logic [LAT-1:0] pipe_d;

            always_comb begin
                pipe_d    = pipe_q << 1;
                pipe_d[0] = in_bit;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign out_bit = pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong frame buffer controller. A packer fills the writer bank while a
// reader drains the other; a reader frame-start swaps the banks only if the
// writer bank holds a complete frame.
//   clk, rst            : clock, asynchronous active-low reset
//   wr_valid/data/last  : packer word stream
//   rd_frame_start      : reader swap request
//   rd_en, rd_addr_in   : reader read strobe and address
//   bank_sel            : bank owned by the reader (writer owns the other)
//   ram_addr_wr, ram_wdata, wren0/1 : write port to both RAMs
//   ram_addr_rd, rden0/1, q0/q1     : read port to both RAMs
//   rd_data             : reader data, muxed with the latency-aligned select
//   overrun / underrun  : one-cycle pulses for a dropped write / refused swap
//   swap_cnt            : number of granted swaps (wraps)
//
// state | meaning
// INIT  | no complete bank yet, rd_data held at 0
// RUN   | first swap granted, banks alternate from here on
module pingpong_ctrl
    import pingpong_ctrl_pkg::*;
#(
    parameter int AW     = PP_AW,
    parameter int DW     = PP_DW,
    parameter int DEPTH  = PP_DEPTH,
    parameter int RD_LAT = PP_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          rd_frame_start,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr_in,
    output logic          bank_sel,
    output logic [AW-1:0] ram_addr_wr,
    output logic [DW-1:0] ram_wdata,
    output logic          wren0,
    output logic          wren1,
    output logic          rden0,
    output logic          rden1,
    output logic [AW-1:0] ram_addr_rd,
    input  logic [DW-1:0] q0,
    input  logic [DW-1:0] q1,
    output logic [DW-1:0] rd_data,
    output logic          overrun,
    output logic          underrun,
    output logic [15:0]   swap_cnt
);

    logic [0:0]    state_q, state_d;
    logic          bank_sel_q, bank_sel_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]    full_q, full_d;
    logic [15:0]   swap_cnt_q, swap_cnt_d;
    logic          overrun_q, overrun_d;
    logic          underrun_q, underrun_d;

    logic          wr_bank;
    logic          wr_full;
    logic          wr_accept;
    logic          wr_close;
    logic          swap_grant;
    logic [1:0]    wren_v;
    logic [1:0]    rden_v;
    logic [AW-1:0] addr_wr;
    logic          sel_dly;

    always_comb begin
        wr_bank    = ~bank_sel_q;
        wr_full    = full_q[wr_bank];
        wr_accept  = wr_valid & ~wr_full;
        // the bank closes on its last word, either flagged or by running out of room
        wr_close   = wr_accept & (wr_last | (wr_ptr_q == AW'(DEPTH - 1)));
        swap_grant = rd_frame_start & (wr_full | wr_close);

        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q;
        swap_cnt_d = swap_cnt_q;
        wren_v     = 2'b00;
        addr_wr    = wr_ptr_q;

        if (wr_accept) begin
            wren_v[wr_bank] = 1'b1;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (wr_close) begin
                full_d[wr_bank] = 1'b1;
            end
        end

        if (swap_grant) begin
            state_d            = ST_RUN;
            bank_sel_d         = wr_bank;
            full_d[bank_sel_q] = 1'b0;
            wr_ptr_d           = '0;
            swap_cnt_d         = swap_cnt_q + 16'd1;
            // a word arriving on a swap out of a full bank is the first word
            // of the freshly released bank
            if (wr_valid && wr_full) begin
                wren_v[bank_sel_q] = 1'b1;
                addr_wr            = '0;
                wr_ptr_d           = AW'(1);
                full_d[bank_sel_q] = wr_last;
            end
        end

        overrun_d  = wr_valid & wr_full & ~swap_grant;
        underrun_d = rd_frame_start & ~swap_grant;

        // a redirected write lands on the current reader bank; the write wins
        rden_v             = 2'b00;
        rden_v[bank_sel_q] = rd_en & ~wren_v[bank_sel_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            bank_sel_q <= 1'b0;
            wr_ptr_q   <= '0;
            full_q     <= 2'b00;
            swap_cnt_q <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            swap_cnt_q <= swap_cnt_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    pp_delay #(
        .LAT (RD_LAT)
    ) u_sel_dly (
        .clk     (clk),
        .rst     (rst),
        .in_bit  (bank_sel_q),
        .out_bit (sel_dly)
    );

    // strobes are gated by rst so nothing reaches the RAMs while reset is held
    assign wren0       = wren_v[0] & rst;
    assign wren1       = wren_v[1] & rst;
    assign rden0       = rden_v[0] & rst;
    assign rden1       = rden_v[1] & rst;
    assign ram_addr_wr = addr_wr;
    assign ram_wdata   = wr_data;
    assign ram_addr_rd = rd_addr_in;
    assign rd_data     = (state_q == ST_INIT) ? '0 : (sel_dly ? q1 : q0);
    assign bank_sel    = bank_sel_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;
    assign swap_cnt    = swap_cnt_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
module tb_pingpong_ctrl;
    import pingpong_ctrl_pkg::*;

    localparam int AW     = 11;
    localparam int DW     = 12;
    localparam int DEPTH  = 2048;
    localparam int RD_LAT = 2;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          rd_frame_start;
    logic          rd_en;
    logic [AW-1:0] rd_addr_in;
    logic          bank_sel;
    logic [AW-1:0] ram_addr_wr;
    logic [DW-1:0] ram_wdata;
    logic          wren0, wren1, rden0, rden1;
    logic [AW-1:0] ram_addr_rd;
    logic [DW-1:0] q0, q1;
    logic [DW-1:0] rd_data;
    logic          overrun, underrun;
    logic [15:0]   swap_cnt;

    pingpong_ctrl #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .rd_frame_start(rd_frame_start), .rd_en(rd_en), .rd_addr_in(rd_addr_in),
        .bank_sel(bank_sel), .ram_addr_wr(ram_addr_wr), .ram_wdata(ram_wdata),
        .wren0(wren0), .wren1(wren1), .rden0(rden0), .rden1(rden1),
        .ram_addr_rd(ram_addr_rd), .q0(q0), .q1(q1), .rd_data(rd_data),
        .overrun(overrun), .underrun(underrun), .swap_cnt(swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: counts and flags per bank ----------------
    int m_rdr;
    int m_cnt[2];
    bit m_full[2];
    bit m_run;
    int m_swaps;
    bit m_ov, m_ud;
    int m_hist[$];

    function automatic void model_reset();
        m_rdr = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_full[0] = 0; m_full[1] = 0;
        m_run = 0; m_swaps = 0; m_ov = 0; m_ud = 0;
        m_hist = {};
        for (int i = 0; i < RD_LAT; i++) m_hist.push_back(0);
    endfunction

    task automatic model_check();
        int wb;
        int wbank;
        int eaddr;
        logic [DW-1:0] erd;
        wb    = 1 - m_rdr;
        wbank = -1;
        eaddr = 0;
        if (wr_valid && m_full[wb] && rd_frame_start) begin
            wbank = m_rdr; eaddr = 0;
        end else if (wr_valid && !m_full[wb]) begin
            wbank = wb; eaddr = m_cnt[wb];
        end
        erd = !m_run ? '0 : (m_hist[0] == 1 ? q1 : q0);
        chk("m_wren0", 32'(wren0), 32'(wbank == 0));
        chk("m_wren1", 32'(wren1), 32'(wbank == 1));
        if (wbank >= 0) chk("m_addr_wr", 32'(ram_addr_wr), 32'(eaddr));
        chk("m_rden0", 32'(rden0), 32'(m_rdr == 0 && rd_en && wbank != 0));
        chk("m_rden1", 32'(rden1), 32'(m_rdr == 1 && rd_en && wbank != 1));
        chk("m_addr_rd", 32'(ram_addr_rd), 32'(rd_addr_in));
        chk("m_wdata", 32'(ram_wdata), 32'(wr_data));
        chk("m_rd_data", 32'(rd_data), 32'(erd));
        chk("m_bank_sel", 32'(bank_sel), 32'(m_rdr));
        chk("m_swap_cnt", 32'(swap_cnt), 32'(m_swaps));
        chk("m_overrun", 32'(overrun), 32'(m_ov));
        chk("m_underrun", 32'(underrun), 32'(m_ud));
    endtask

    function automatic void model_step();
        int wb;
        int old;
        bit full, acc, closes, grant;
        wb     = 1 - m_rdr;
        full   = m_full[wb];
        acc    = wr_valid && !full;
        closes = acc && (wr_last || m_cnt[wb] == DEPTH - 1);
        grant  = rd_frame_start && (full || closes);
        m_hist.push_back(m_rdr);
        if (m_hist.size() > RD_LAT) void'(m_hist.pop_front());
        m_ov = wr_valid && full && !rd_frame_start;
        m_ud = rd_frame_start && !grant;
        if (acc) begin
            m_cnt[wb]++;
            if (closes) m_full[wb] = 1;
        end
        if (grant) begin
            old = m_rdr;
            m_rdr = wb;
            m_full[old] = 0;
            m_cnt[old] = 0;
            m_swaps = (m_swaps + 1) % 65536;
            m_run = 1;
            if (wr_valid && full) begin
                m_cnt[old] = 1;
                m_full[old] = wr_last;
            end
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_data = '0; wr_last = 0; rd_frame_start = 0; rd_en = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit wv; logic [DW-1:0] wd; bit wl; bit fs; bit re;
        bit ew0; bit ew1; int eaddr; bit er0; bit er1;
        bit ebs; int esc; bit eov; bit eud; logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{0, 12'h000, 0, 1, 1,  0, 0, -1, 1, 0,  0, 0, 0, 0, 12'h000};
        tbl[1]  = '{0, 12'h000, 0, 0, 0,  0, 0, -1, 0, 0,  0, 0, 0, 1, 12'h000};
        tbl[2]  = '{1, 12'h101, 0, 0, 1,  0, 1,  0, 1, 0,  0, 0, 0, 0, 12'h000};
        tbl[3]  = '{1, 12'h102, 0, 0, 0,  0, 1,  1, 0, 0,  0, 0, 0, 0, 12'h000};
        tbl[4]  = '{1, 12'h103, 0, 0, 0,  0, 1,  2, 0, 0,  0, 0, 0, 0, 12'h000};
        tbl[5]  = '{1, 12'h104, 0, 0, 0,  0, 1,  3, 0, 0,  0, 0, 0, 0, 12'h000};
        tbl[6]  = '{1, 12'h105, 1, 0, 0,  0, 1,  4, 0, 0,  0, 0, 0, 0, 12'h000};
        tbl[7]  = '{1, 12'h106, 0, 0, 0,  0, 0, -1, 0, 0,  0, 0, 0, 0, 12'h000};
        tbl[8]  = '{0, 12'h000, 0, 0, 0,  0, 0, -1, 0, 0,  0, 0, 1, 0, 12'h000};
        tbl[9]  = '{0, 12'h000, 0, 1, 1,  0, 0, -1, 1, 0,  0, 0, 0, 0, 12'h000};
        tbl[10] = '{1, 12'h201, 0, 0, 1,  1, 0,  0, 0, 1,  1, 1, 0, 0, 12'hAAA};
        tbl[11] = '{1, 12'h202, 1, 1, 0,  1, 0,  1, 0, 0,  1, 1, 0, 0, 12'hAAA};
        tbl[12] = '{1, 12'h203, 0, 0, 1,  0, 1,  0, 1, 0,  0, 2, 0, 0, 12'h555};
        tbl[13] = '{0, 12'h000, 0, 0, 0,  0, 0, -1, 0, 0,  0, 2, 0, 0, 12'h555};
        tbl[14] = '{1, 12'h204, 1, 0, 0,  0, 1,  1, 0, 0,  0, 2, 0, 0, 12'hAAA};
        tbl[15] = '{1, 12'h301, 0, 1, 1,  1, 0,  0, 0, 0,  0, 2, 0, 0, 12'hAAA};
        tbl[16] = '{1, 12'h302, 0, 0, 1,  1, 0,  1, 0, 1,  1, 3, 0, 0, 12'hAAA};
        tbl[17] = '{0, 12'h000, 0, 0, 0,  0, 0, -1, 0, 0,  1, 3, 0, 0, 12'hAAA};
        tbl[18] = '{0, 12'h000, 0, 0, 0,  0, 0, -1, 0, 0,  1, 3, 0, 0, 12'h555};
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        rd_addr_in = '0;
        q0 = 12'hAAA;
        q1 = 12'h555;
        model_reset();
        #12;
        rst = 1'b1;
        tick();

        // directed table: reset behaviour, fill/overrun, swaps, redirect
        for (int i = 0; i < 19; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; wr_last = tbl[i].wl;
            rd_frame_start = tbl[i].fs; rd_en = tbl[i].re; rd_addr_in = AW'(i * 37);
            settle();
            chk($sformatf("t%0d_wren0", i), 32'(wren0), 32'(tbl[i].ew0));
            chk($sformatf("t%0d_wren1", i), 32'(wren1), 32'(tbl[i].ew1));
            if (tbl[i].eaddr >= 0)
                chk($sformatf("t%0d_addr_wr", i), 32'(ram_addr_wr), 32'(tbl[i].eaddr));
            chk($sformatf("t%0d_rden0", i), 32'(rden0), 32'(tbl[i].er0));
            chk($sformatf("t%0d_rden1", i), 32'(rden1), 32'(tbl[i].er1));
            chk($sformatf("t%0d_bank_sel", i), 32'(bank_sel), 32'(tbl[i].ebs));
            chk($sformatf("t%0d_swap_cnt", i), 32'(swap_cnt), 32'(tbl[i].esc));
            chk($sformatf("t%0d_overrun", i), 32'(overrun), 32'(tbl[i].eov));
            chk($sformatf("t%0d_underrun", i), 32'(underrun), 32'(tbl[i].eud));
            chk($sformatf("t%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].erd));
            tick();
        end

        // read issued the cycle before a swap returns the old bank's data
        q0 = 12'h0A0;
        q1 = 12'h0B1;
        idle_inputs();
        wr_valid = 1; wr_data = 12'h3FF; wr_last = 1; rd_en = 1;
        settle(); chk("lat_rden1", 32'(rden1), 32'd1); tick();
        idle_inputs(); rd_frame_start = 1;
        settle(); tick();
        idle_inputs();
        settle(); chk("lat_bank_sel", 32'(bank_sel), 32'd0);
        chk("lat_old_bank", 32'(rd_data), 32'h0B1); tick();
        settle(); chk("lat_inflight", 32'(rd_data), 32'h0B1); tick();
        settle(); chk("lat_new_bank", 32'(rd_data), 32'h0A0); tick();

        // swap back to bank 1 using a coincident last/frame-start, then start a frame
        wr_valid = 1; wr_data = 12'h011; wr_last = 1; rd_frame_start = 1;
        settle(); tick();
        idle_inputs(); wr_valid = 1; wr_data = 12'h012;
        settle(); chk("pre_rst_wren0", 32'(wren0), 32'd1); tick();
        wr_data = 12'h013;
        settle(); tick();

        // asynchronous reset mid-frame with strobes still requested
        wr_valid = 1; wr_data = 12'h555; rd_en = 1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wren0", 32'(wren0), 32'd0);
        chk("arst_wren1", 32'(wren1), 32'd0);
        chk("arst_rden0", 32'(rden0), 32'd0);
        chk("arst_rden1", 32'(rden1), 32'd0);
        chk("arst_bank_sel", 32'(bank_sel), 32'd0);
        chk("arst_swap_cnt", 32'(swap_cnt), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_addr_wr", 32'(ram_addr_wr), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        model_reset();
        @(posedge clk); #1;
        chk("arst_hold_wren1", 32'(wren1), 32'd0);
        chk("arst_hold_rden0", 32'(rden0), 32'd0);
        @(negedge clk); #2;
        idle_inputs();
        rst = 1'b1;
        tick();

        // full bank by running out of room; partial frame was discarded
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1; wr_data = DW'(i); wr_last = 0;
            settle();
            if (i == 0) begin
                chk("depth_first_wren1", 32'(wren1), 32'd1);
                chk("depth_first_addr", 32'(ram_addr_wr), 32'd0);
            end
            if (i == DEPTH - 1) begin
                chk("depth_last_wren1", 32'(wren1), 32'd1);
                chk("depth_last_addr", 32'(ram_addr_wr), 32'(DEPTH - 1));
            end
            tick();
        end
        settle();
        chk("depth_drop_wren1", 32'(wren1), 32'd0);
        chk("depth_drop_wren0", 32'(wren0), 32'd0);
        tick();
        idle_inputs();
        settle(); chk("depth_overrun", 32'(overrun), 32'd1); tick();
        rd_frame_start = 1;
        settle(); tick();
        idle_inputs();
        settle();
        chk("depth_swap_bank", 32'(bank_sel), 32'd1);
        chk("depth_swap_cnt", 32'(swap_cnt), 32'd1);
        chk("depth_no_underrun", 32'(underrun), 32'd0);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr_valid       = ($urandom_range(0, 9) < 6);
            wr_data        = DW'($urandom);
            wr_last        = ($urandom_range(0, 7) == 0);
            rd_frame_start = ($urandom_range(0, 15) == 0);
            rd_en          = $urandom_range(0, 1) == 1;
            rd_addr_in     = AW'($urandom);
            q0             = DW'($urandom);
            q1             = DW'($urandom);
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
